// File: rtl/if_id_stage_reg.sv
// IF->ID pipeline register with valid/ready on both sides, optional 2-entry skid buffer,
// flush with NOP injection, fetch-fault tag and saturating stall/bubble counters.
module if_id_stage_reg #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013,
  parameter bit                    SKID_EN    = 1'b1,
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_instr_i,
  input  logic [DATA_WIDTH-1:0] in_pc_i,
  input  logic [DATA_WIDTH-1:0] in_pc_plus4_i,
  input  logic                  in_fault_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_instr_o,
  output logic [DATA_WIDTH-1:0] out_pc_o,
  output logic [DATA_WIDTH-1:0] out_pc_plus4_o,
  output logic                  out_fault_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  bubble_cnt_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  fault;
  } entry_t;

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;

  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;

  entry_t in_entry;
  logic   in_xfer;
  logic   main_free;

  assign in_entry.instr    = in_instr_i;
  assign in_entry.pc       = in_pc_i;
  assign in_entry.pc_plus4 = in_pc_plus4_i;
  assign in_entry.fault    = in_fault_i;

  // Main can take a new entry when it is empty or its current entry leaves this cycle.
  assign main_free = ~main_valid_q | out_ready_i;

  generate
    if (SKID_EN) begin : g_ready_skid
      assign in_ready_o = ~skid_valid_q;
    end else begin : g_ready_flow
      assign in_ready_o = main_free;
    end
  endgenerate

  assign in_xfer = in_valid_i & in_ready_o;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      // Payload is kept so pc/pc_plus4 hold; only the valid bits are killed.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (SKID_EN && in_xfer) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid_q && !out_ready_i && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (!main_valid_q && (bubble_cnt_q != CntMax)) begin
      bubble_cnt_d = bubble_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid_o    = main_valid_q;
  assign out_instr_o    = main_valid_q ? main_q.instr : NOP_INSTR;
  assign out_fault_o    = main_valid_q & main_q.fault;
  assign out_pc_o       = main_q.pc;
  assign out_pc_plus4_o = main_q.pc_plus4;
  assign stall_cnt_o    = stall_cnt_q;
  assign bubble_cnt_o   = bubble_cnt_q;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: three instances (skid, flow-through, 4-bit counters) checked
// every cycle against a FIFO-level model, plus hand-computed literal expectations.
module tb_if_id_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fault;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        rst_req = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_fault = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_pc4 = '0;

  logic        o_ready [3];
  logic        o_valid [3];
  logic        o_fault [3];
  logic [31:0] o_instr [3];
  logic [31:0] o_pc    [3];
  logic [31:0] o_pc4   [3];
  logic [15:0] s_stall [2];
  logic [15:0] s_bub   [2];
  logic [3:0]  sat_stall, sat_bub;

  if_id_stage_reg #(.DATA_WIDTH(32), .NOP_INSTR(NOP), .SKID_EN(1'b1), .CNT_WIDTH(16)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(o_ready[0]),
    .in_instr_i(in_instr), .in_pc_i(in_pc), .in_pc_plus4_i(in_pc4), .in_fault_i(in_fault),
    .out_valid_o(o_valid[0]), .out_ready_i(out_ready), .out_instr_o(o_instr[0]),
    .out_pc_o(o_pc[0]), .out_pc_plus4_o(o_pc4[0]), .out_fault_o(o_fault[0]),
    .stall_cnt_o(s_stall[0]), .bubble_cnt_o(s_bub[0])
  );

  if_id_stage_reg #(.DATA_WIDTH(32), .NOP_INSTR(NOP), .SKID_EN(1'b0), .CNT_WIDTH(16)) u_flow (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(o_ready[1]),
    .in_instr_i(in_instr), .in_pc_i(in_pc), .in_pc_plus4_i(in_pc4), .in_fault_i(in_fault),
    .out_valid_o(o_valid[1]), .out_ready_i(out_ready), .out_instr_o(o_instr[1]),
    .out_pc_o(o_pc[1]), .out_pc_plus4_o(o_pc4[1]), .out_fault_o(o_fault[1]),
    .stall_cnt_o(s_stall[1]), .bubble_cnt_o(s_bub[1])
  );

  if_id_stage_reg #(.DATA_WIDTH(32), .NOP_INSTR(NOP), .SKID_EN(1'b1), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(o_ready[2]),
    .in_instr_i(in_instr), .in_pc_i(in_pc), .in_pc_plus4_i(in_pc4), .in_fault_i(in_fault),
    .out_valid_o(o_valid[2]), .out_ready_i(out_ready), .out_instr_o(o_instr[2]),
    .out_pc_o(o_pc[2]), .out_pc_plus4_o(o_pc4[2]), .out_fault_o(o_fault[2]),
    .stall_cnt_o(sat_stall), .bubble_cnt_o(sat_bub)
  );

  function automatic logic [31:0] get_stall(input int i);
    return (i == 2) ? 32'(sat_stall) : 32'(s_stall[i]);
  endfunction

  function automatic logic [31:0] get_bub(input int i);
    return (i == 2) ? 32'(sat_bub) : 32'(s_bub[i]);
  endfunction

  // Model: each instance is a FIFO of depth 2 (skid) or 1 (flow-through).
  int          depth [3] = '{2, 1, 2};
  int unsigned cmax  [3] = '{65535, 65535, 15};
  ent_t        mq    [3][2];
  int          msz   [3] = '{0, 0, 0};
  logic [31:0] mpc   [3] = '{0, 0, 0};
  logic [31:0] mpc4  [3] = '{0, 0, 0};
  int unsigned mstl  [3] = '{0, 0, 0};
  int unsigned mbub  [3] = '{0, 0, 0};

  function automatic logic m_ready(input int i);
    if (depth[i] == 2) return msz[i] < 2;
    return (msz[i] == 0) || out_ready;
  endfunction

  task automatic m_step(input int i);
    logic rdy;
    logic vld;
    ent_t e;
    rdy = m_ready(i);
    vld = msz[i] > 0;
    if (!rst_n) begin
      msz[i]  = 0;
      mpc[i]  = '0;
      mpc4[i] = '0;
      mstl[i] = 0;
      mbub[i] = 0;
    end else begin
      if (!vld && mbub[i] < cmax[i]) mbub[i]++;
      if (vld && !out_ready && mstl[i] < cmax[i]) mstl[i]++;
      if (flush) begin
        msz[i] = 0;
      end else begin
        if (vld && out_ready) begin
          mq[i][0] = mq[i][1];
          msz[i]--;
        end
        if (in_valid && rdy) begin
          e.instr = in_instr;
          e.pc = in_pc;
          e.pc4 = in_pc4;
          e.fault = in_fault;
          mq[i][msz[i]] = e;
          msz[i]++;
        end
      end
      if (msz[i] > 0) begin
        mpc[i]  = mq[i][0].pc;
        mpc4[i] = mq[i][0].pc4;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) m_step(i);
  end

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] at %0t: got %h, expected %h", name, inst, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        logic v;
        v = msz[i] > 0;
        chk("valid", i, 32'(o_valid[i]), 32'(v));
        chk("in_ready", i, 32'(o_ready[i]), 32'(m_ready(i)));
        chk("instr", i, o_instr[i], v ? mq[i][0].instr : NOP);
        chk("fault", i, 32'(o_fault[i]), v ? 32'(mq[i][0].fault) : 32'd0);
        chk("pc", i, o_pc[i], mpc[i]);
        chk("pc4", i, o_pc4[i], mpc4[i]);
        chk("stall_cnt", i, get_stall(i), mstl[i]);
        chk("bubble_cnt", i, get_bub(i), mbub[i]);
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc, input logic f, input logic ordy,
                     input logic fl);
    @(negedge clk);
    rst_n     = rst_req;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = pc ^ 32'h0050_0093;
    in_pc4    = pc + 32'd4;
    in_fault  = f;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input int i);
    chk("rst_valid", i, 32'(o_valid[i]), 32'd0);
    chk("rst_ready", i, 32'(o_ready[i]), 32'd1);
    chk("rst_instr", i, o_instr[i], NOP);
    chk("rst_pc", i, o_pc[i], 32'd0);
    chk("rst_pc4", i, o_pc4[i], 32'd0);
    chk("rst_fault", i, 32'(o_fault[i]), 32'd0);
    chk("rst_stall", i, get_stall(i), 32'd0);
    chk("rst_bubble", i, get_bub(i), 32'd0);
  endtask

  initial begin
    rst_req = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checking = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk_reset(0);
    rst_req = 1'b1;

    // Streaming with decode always ready.
    cyc(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("lit_stream_pc0", 0, o_pc[0], 32'h0);
    cyc(1'b1, 32'h4, 1'b0, 1'b1, 1'b0);
    chk("lit_stream_pc4", 0, o_pc[0], 32'h4);
    chk("lit_stream_rdy", 0, 32'(o_ready[0]), 32'd1);
    cyc(1'b1, 32'h8, 1'b0, 1'b1, 1'b0);
    chk("lit_stream_pc8", 0, o_pc[0], 32'h8);
    chk("lit_stream_bub", 0, get_bub(0), 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: A held, B goes to skid.
    cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    chk("lit_skid_rdy", 0, 32'(o_ready[0]), 32'd0);
    chk("lit_skid_hold", 0, o_pc[0], 32'h40);
    cyc(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    chk("lit_skid_stall", 0, get_stall(0), 32'd2);
    cyc(1'b1, 32'h44, 1'b0, 1'b1, 1'b0);
    chk("lit_skid_b", 0, o_pc[0], 32'h44);
    chk("lit_skid_rdy1", 0, 32'(o_ready[0]), 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Flush with both entries full and an incoming entry.
    cyc(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h84, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    chk("lit_flush_valid", 0, 32'(o_valid[0]), 32'd0);
    chk("lit_flush_instr", 0, o_instr[0], 32'h13);
    chk("lit_flush_rdy", 0, 32'(o_ready[0]), 32'd1);
    chk("lit_flush_pc", 0, o_pc[0], 32'h80);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("lit_flush_gone", 0, 32'(o_valid[0]), 32'd0);

    // Fault tag follows its entry.
    cyc(1'b1, 32'h20, 1'b1, 1'b0, 1'b0);
    chk("lit_fault_set", 0, 32'(o_fault[0]), 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_fault_hold", 0, 32'(o_fault[0]), 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("lit_fault_clr", 0, 32'(o_fault[0]), 32'd0);

    // Flow-through: in_ready follows out_ready combinationally.
    cyc(1'b1, 32'h30, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("lit_flow_rdy0", 1, 32'(o_ready[1]), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("lit_flow_rdy1", 1, 32'(o_ready[1]), 32'd1);
    @(posedge clk);
    #1;

    // Long stall: 4-bit counter saturates.
    cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_sat_stall", 2, get_stall(2), 32'd15);
    chk("lit_wide_stall", 0, get_stall(0), 32'd25);

    // Reset in the middle of the stall.
    rst_req = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_reset(0);
    chk_reset(2);
    rst_req = 1'b1;
    cyc(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
